// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port frame-buffer RAM between VGA scan-out
// reads, a posted host write FIFO and a full-screen fill engine. Display reads
// own the RAM during active video; fill and FIFO writes use blanking cycles.
module vram_arbiter #(
   parameter int FIFO_DEPTH = 4,
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480
) (
   input  logic        clk,
   input  logic        clear,
   input  logic        valid,
   input  logic [9:0]  h_addr,
   input  logic [9:0]  v_addr,
   output logic [11:0] pix_data,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [18:0] wr_addr,
   input  logic [11:0] wr_data,
   input  logic        fill_start,
   input  logic [11:0] fill_color,
   output logic        fill_busy,
   output logic [18:0] mem_addr,
   output logic        mem_we,
   output logic [11:0] mem_wdata,
   input  logic [11:0] mem_rdata
);

   localparam int            AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
   localparam logic [9:0]    H_LAST   = 10'(H_ACTIVE - 1);
   localparam logic [8:0]    V_LAST   = 9'(V_ACTIVE - 1);

   typedef enum logic [1:0] {G_IDLE, G_DISP, G_FILL, G_DRAIN} grant_e;
   typedef enum logic       {F_IDLE, F_RUN} fill_state_e;

   typedef struct packed {
      logic [18:0] addr;
      logic [11:0] data;
   } wr_entry_t;

   // Registered state
   fill_state_e fstate_q, fstate_d;
   logic [9:0]  fh_q, fh_d;
   logic [8:0]  fv_q, fv_d;
   logic [11:0] color_q, color_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [11:0] pix_q, pix_d;
   logic        rd_pend_q, rd_pend_d;
   wr_entry_t   fifo_mem_q [FIFO_DEPTH];

   // Combinational helpers
   grant_e      grant;
   wr_entry_t   head;
   logic        fifo_empty;
   logic        fifo_full;
   logic        push;
   logic        unused_v_msb;

   assign unused_v_msb = v_addr[9];

   // FIFO occupancy from wrap-bit pointers
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push       = wr_valid && !fifo_full;
   assign head       = fifo_mem_q[rd_ptr_q[AW-1:0]];

   assign wr_ready   = !fifo_full;
   assign fill_busy  = (fstate_q == F_RUN);
   assign pix_data   = pix_q;

   // Per-cycle RAM grant: display, then fill, then FIFO drain
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      grant     = G_IDLE;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (valid) begin
         grant    = G_DISP;
         mem_addr = {h_addr, v_addr[8:0]};
      end else if (fstate_q == F_RUN) begin
         grant     = G_FILL;
         mem_addr  = {fh_q, fv_q};
         mem_we    = 1'b1;
         mem_wdata = color_q;
      end else if (!fifo_empty) begin
         grant     = G_DRAIN;
         mem_addr  = head.addr;
         mem_we    = 1'b1;
         mem_wdata = head.data;
      end
   end

   // Next-state for fill sweep, FIFO pointers and pixel output
   always_comb begin
      fstate_d  = fstate_q;
      fh_d      = fh_q;
      fv_d      = fv_q;
      color_d   = color_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      rd_pend_d = (grant == G_DISP);
      pix_d     = rd_pend_q ? mem_rdata : 12'h000;

      if (push)
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (grant == G_DRAIN)
         rd_ptr_d = rd_ptr_q + PTR_ONE;

      case (fstate_q)
         F_IDLE: begin
            // A start with writes still queued is dropped, not deferred
            if (fill_start && fifo_empty) begin
               fstate_d = F_RUN;
               color_d  = fill_color;
               fh_d     = '0;
               fv_d     = '0;
            end
         end
         F_RUN: begin
            // Column-major sweep: rows advance first, then the column
            if (grant == G_FILL) begin
               if (fv_q == V_LAST) begin
                  fv_d = '0;
                  if (fh_q == H_LAST)
                     fstate_d = F_IDLE;
                  else
                     fh_d = fh_q + 10'd1;
               end else begin
                  fv_d = fv_q + 9'd1;
               end
            end
         end
         default: fstate_d = F_IDLE;
      endcase
   end

   // State registers; clear aborts the fill and discards queued writes
   always_ff @(posedge clk or posedge clear) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (clear) begin
         fstate_q  <= F_IDLE;
         fh_q      <= '0;
         fv_q      <= '0;
         color_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         pix_q     <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         fstate_q  <= fstate_d;
         fh_q      <= fh_d;
         fv_q      <= fv_d;
         color_q   <= color_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         pix_q     <= pix_d;
         rd_pend_q <= rd_pend_d;
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; the pointers alone define valid entries.
      if (push)
         fifo_mem_q[wr_ptr_q[AW-1:0]] <= '{addr: wr_addr, data: wr_data};
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a small fill window (4x3) and a
// behavioural single-port RAM with one-cycle read latency.
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        clear;
   logic        valid;
   logic [9:0]  h_addr;
   logic [9:0]  v_addr;
   logic [11:0] pix_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [18:0] wr_addr;
   logic [11:0] wr_data;
   logic        fill_start;
   logic [11:0] fill_color;
   logic        fill_busy;
   logic [18:0] mem_addr;
   logic        mem_we;
   logic [11:0] mem_wdata;
   logic [11:0] mem_rdata;

   logic        pre_we;
   logic [18:0] pre_addr;
   logic [11:0] pre_data;
   logic [11:0] ram [0:524287];

   int n_assert = 0;
   int n_fail   = 0;
   int writes;

   always #5 clk = ~clk;

   vram_arbiter #(
      .FIFO_DEPTH (4),
      .H_ACTIVE   (4),
      .V_ACTIVE   (3)
   ) dut (
      .clk        (clk),
      .clear      (clear),
      .valid      (valid),
      .h_addr     (h_addr),
      .v_addr     (v_addr),
      .pix_data   (pix_data),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .fill_start (fill_start),
      .fill_color (fill_color),
      .fill_busy  (fill_busy),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // Single-port synchronous RAM, read-before-write, plus a preload port
   always @(posedge clk) begin
      mem_rdata <= ram[mem_addr];
      if (pre_we)
         ram[pre_addr] <= pre_data;
      else if (mem_we)
         ram[mem_addr] <= mem_wdata;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [18:0] pa(input int h, input int v);
      return {10'(h), 9'(v)};
   endfunction

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clear = 1'b1; valid = 1'b0; h_addr = '0; v_addr = '0;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      fill_start = 1'b0; fill_color = '0;
      pre_we = 1'b0; pre_addr = '0; pre_data = '0;

      // Preload RAM[{5,7}] while held in reset
      tick();
      pre_we = 1'b1; pre_addr = 19'h00A07; pre_data = 12'hABC;
      tick();
      pre_we = 1'b0;
      #1;
      check("rst_pix",   32'(pix_data),  32'h0);
      check("rst_busy",  32'(fill_busy), 32'h0);
      check("rst_ready", 32'(wr_ready),  32'h1);
      check("rst_we",    32'(mem_we),    32'h0);
      check("rst_addr",  32'(mem_addr),  32'h0);
      check("rst_wdata", 32'(mem_wdata), 32'h0);
      clear = 1'b0;
      tick();

      // Display read latency
      valid = 1'b1; h_addr = 10'd5; v_addr = 10'd7;
      #1;
      check("disp_addr", 32'(mem_addr), 32'h00A07);
      check("disp_we",   32'(mem_we),   32'h0);
      tick();
      valid = 1'b0; h_addr = '0; v_addr = '0;
      #1;
      check("pix_early", 32'(pix_data), 32'h0);
      tick();
      check("pix_n2",    32'(pix_data), 32'hABC);
      tick();
      check("pix_blank", 32'(pix_data), 32'h0);

      // Five pushes during active video into a 4-deep FIFO
      valid = 1'b1; h_addr = 10'd5; v_addr = 10'd7;
      for (int i = 0; i < 5; i++) begin
         wr_valid = 1'b1; wr_addr = 19'h10000 + 19'(i); wr_data = 12'h100 + 12'(i);
         #1;
         check("push_ready", 32'(wr_ready), (i < 4) ? 32'h1 : 32'h0);
         check("push_no_we", 32'(mem_we),   32'h0);
         tick();
      end
      wr_valid = 1'b0; valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("drain_we",    32'(mem_we),    32'h1);
         check("drain_addr",  32'(mem_addr),  32'h10000 + 32'(i));
         check("drain_wdata", 32'(mem_wdata), 32'h100 + 32'(i));
         check("drain_ready", 32'(wr_ready),  (i != 0) ? 32'h1 : 32'h0);
         tick();
      end
      #1;
      check("drain_done_we",    32'(mem_we),   32'h0);
      check("drain_done_ready", 32'(wr_ready), 32'h1);

      // Fill in blanking only
      fill_start = 1'b1; fill_color = 12'hF00;
      #1;
      check("fill_busy_pre", 32'(fill_busy), 32'h0);
      tick();
      fill_start = 1'b0; fill_color = '0;
      for (int k = 0; k < 12; k++) begin
         #1;
         check("fill_busy",  32'(fill_busy), 32'h1);
         check("fill_we",    32'(mem_we),    32'h1);
         check("fill_addr",  32'(mem_addr),  32'(pa(k / 3, k % 3)));
         check("fill_wdata", 32'(mem_wdata), 32'hF00);
         tick();
      end
      #1;
      check("fill_end_busy", 32'(fill_busy), 32'h0);
      check("fill_end_we",   32'(mem_we),    32'h0);

      // Fill interleaved with display; restart attempt while busy
      fill_start = 1'b1; fill_color = 12'h0F0;
      tick();
      fill_start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         valid = 1'b1; h_addr = 10'(k); v_addr = 10'd1;
         fill_start = (k == 3); fill_color = 12'h00F;
         #1;
         check("mix_disp_we",   32'(mem_we),    32'h0);
         check("mix_disp_addr", 32'(mem_addr),  32'(pa(k, 1)));
         check("mix_busy",      32'(fill_busy), 32'h1);
         tick();
         valid = 1'b0; fill_start = 1'b0;
         #1;
         check("mix_fill_we",    32'(mem_we),    32'h1);
         check("mix_fill_addr",  32'(mem_addr),  32'(pa(k / 3, k % 3)));
         check("mix_fill_wdata", 32'(mem_wdata), 32'h0F0);
         tick();
      end
      #1;
      check("mix_end_busy", 32'(fill_busy), 32'h0);
      tick();
      check("mix_no_restart", 32'(fill_busy), 32'h0);

      // Start ignored while a host write is pending
      valid = 1'b1; h_addr = '0; v_addr = '0;
      wr_valid = 1'b1; wr_addr = 19'h12345; wr_data = 12'h123;
      #1;
      check("pend_ready", 32'(wr_ready), 32'h1);
      tick();
      wr_valid = 1'b0; fill_start = 1'b1; fill_color = 12'hFFF;
      #1;
      check("pend_busy0", 32'(fill_busy), 32'h0);
      tick();
      fill_start = 1'b0; valid = 1'b0;
      #1;
      check("pend_ignored", 32'(fill_busy), 32'h0);
      check("pend_we",      32'(mem_we),    32'h1);
      check("pend_addr",    32'(mem_addr),  32'h12345);
      check("pend_wdata",   32'(mem_wdata), 32'h123);
      tick();
      #1;
      check("pend_done_we",   32'(mem_we),    32'h0);
      check("pend_done_busy", 32'(fill_busy), 32'h0);

      // Host push during fill drains after the last fill write
      fill_start = 1'b1; fill_color = 12'hAAA;
      tick();
      fill_start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         wr_valid = (k == 0); wr_addr = 19'h54321; wr_data = 12'h555;
         #1;
         check("post_fill_we",    32'(mem_we),    32'h1);
         check("post_fill_addr",  32'(mem_addr),  32'(pa(k / 3, k % 3)));
         check("post_fill_wdata", 32'(mem_wdata), 32'hAAA);
         tick();
      end
      wr_valid = 1'b0;
      #1;
      check("post_busy",  32'(fill_busy), 32'h0);
      check("post_we",    32'(mem_we),    32'h1);
      check("post_addr",  32'(mem_addr),  32'h54321);
      check("post_wdata", 32'(mem_wdata), 32'h555);
      tick();
      check("post_done_we", 32'(mem_we), 32'h0);

      // Clear mid-fill with two writes queued
      fill_start = 1'b1; fill_color = 12'h777;
      tick();
      fill_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wr_valid = (k < 2); wr_addr = 19'h00100 + 19'(k); wr_data = 12'h0C0 + 12'(k);
         #1;
         check("clr_fill_we",   32'(mem_we),   32'h1);
         check("clr_fill_addr", 32'(mem_addr), 32'(pa(k / 3, k % 3)));
         tick();
      end
      wr_valid = 1'b0;
      clear = 1'b1;
      #1;
      check("clr_busy",  32'(fill_busy), 32'h0);
      check("clr_we",    32'(mem_we),    32'h0);
      check("clr_ready", 32'(wr_ready),  32'h1);
      check("clr_addr",  32'(mem_addr),  32'h0);
      tick();
      clear = 1'b0;
      writes = 0;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (mem_we) writes++;
         tick();
      end
      check("clr_no_writes", 32'(writes),    32'h0);
      check("clr_busy_after", 32'(fill_busy), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
